// File: rtl/ysyx_25040109_trap_ctrl.sv
// rtl/ysyx_25040109_trap_ctrl.sv - trap/mret/CSR-write sequencer sharing the single CSR write port
module ysyx_25040109_trap_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter bit VEC_EN     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trap_valid,
  input  logic [DATA_WIDTH-1:0] trap_pc,
  input  logic [DATA_WIDTH-1:0] trap_cause,
  input  logic                  mret_valid,
  input  logic                  csrw_valid,
  input  logic [11:0]           csrw_addr,
  input  logic [DATA_WIDTH-1:0] csrw_data,
  output logic                  ready,
  output logic                  trap_ack,
  output logic                  mret_ack,
  output logic                  csrw_ack,
  output logic                  csr_we,
  output logic [11:0]           csr_addr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  input  logic [DATA_WIDTH-1:0] mtvec_in,
  input  logic [DATA_WIDTH-1:0] mepc_in,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    IDLE,
    T_MEPC,
    T_MCAUSE,
    T_MSTAT,
    M_MSTAT,
    CSRW,
    REDIR
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] cause_q;
  logic [11:0]           addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  mode_q;

  logic [DATA_WIDTH-1:0] tvec_base;
  logic                  vec_hit;
  logic [DATA_WIDTH-1:0] trap_target;
  logic [DATA_WIDTH-1:0] redir_target;
  logic [DATA_WIDTH-1:0] ms_trap;
  logic [DATA_WIDTH-1:0] ms_mret;

  assign ready    = (state == IDLE);
  assign trap_ack = ready & trap_valid;
  assign mret_ack = ready & mret_valid & ~trap_valid;
  assign csrw_ack = ready & csrw_valid & ~trap_valid & ~mret_valid;

  // Vectored offset is 4*cause[30:0], truncated to the PC width.
  assign tvec_base   = {mtvec_in[DATA_WIDTH-1:2], 2'b00};
  assign vec_hit     = VEC_EN && (mtvec_in[1:0] == 2'b01) && cause_q[DATA_WIDTH-1];
  assign trap_target = vec_hit ? (tvec_base + {cause_q[DATA_WIDTH-3:0], 2'b00}) : tvec_base;
  assign redir_target = mode_q ? trap_target : mepc_in;

  always_comb begin
    ms_trap        = csr_rdata;
    ms_trap[7]     = csr_rdata[3];
    ms_trap[3]     = 1'b0;
    ms_trap[12:11] = 2'b11;
    ms_mret        = csr_rdata;
    ms_mret[3]     = csr_rdata[7];
    ms_mret[7]     = 1'b1;
    ms_mret[12:11] = 2'b11;
  end

  always_comb begin
    csr_we    = 1'b0;
    csr_addr  = 12'h000;
    csr_wdata = '0;
    case (state)
      T_MEPC: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MEPC;
        csr_wdata = pc_q;
      end
      T_MCAUSE: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MCAUSE;
        csr_wdata = cause_q;
      end
      T_MSTAT: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MSTATUS;
        csr_wdata = ms_trap;
      end
      M_MSTAT: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MSTATUS;
        csr_wdata = ms_mret;
      end
      CSRW: begin
        csr_we    = 1'b1;
        csr_addr  = addr_q;
        csr_wdata = data_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      pc_q           <= '0;
      cause_q        <= '0;
      addr_q         <= 12'h000;
      data_q         <= '0;
      mode_q         <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trap_valid || mret_valid || csrw_valid) begin
            pc_q    <= trap_pc;
            cause_q <= trap_cause;
            addr_q  <= csrw_addr;
            data_q  <= csrw_data;
            mode_q  <= trap_valid;
          end
          if (trap_valid)      state <= T_MEPC;
          else if (mret_valid) state <= M_MSTAT;
          else if (csrw_valid) state <= CSRW;
        end
        T_MEPC:   state <= T_MCAUSE;
        T_MCAUSE: state <= T_MSTAT;
        // mtvec/mepc are sampled here so earlier CSR writes are already visible.
        T_MSTAT, M_MSTAT: begin
          state          <= REDIR;
          redirect_valid <= 1'b1;
          redirect_pc    <= redir_target;
        end
        REDIR: begin
          state          <= IDLE;
          redirect_valid <= 1'b0;
        end
        CSRW:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040109_trap_ctrl.sv
// tb/tb_ysyx_25040109_trap_ctrl.sv - self-checking bench for ysyx_25040109_trap_ctrl
module tb_ysyx_25040109_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_pc = '0;
  logic [31:0] trap_cause = '0;
  logic        mret_valid = 1'b0;
  logic        csrw_valid = 1'b0;
  logic [11:0] csrw_addr = '0;
  logic [31:0] csrw_data = '0;
  logic        ready, trap_ack, mret_ack, csrw_ack;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic [31:0] mtvec_in, mepc_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  ysyx_25040109_trap_ctrl #(.DATA_WIDTH(32), .VEC_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .mret_valid(mret_valid),
    .csrw_valid(csrw_valid), .csrw_addr(csrw_addr), .csrw_data(csrw_data),
    .ready(ready), .trap_ack(trap_ack), .mret_ack(mret_ack), .csrw_ack(csrw_ack),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .mtvec_in(mtvec_in), .mepc_in(mepc_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  typedef struct { int cyc; logic [11:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int cyc; logic [31:0] pc; } rd_t;

  wr_t wlog[$];
  rd_t rlog[$];
  wr_t mon_w;
  rd_t mon_r;
  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;

  // CSR register file seen by the DUT
  logic [31:0] m_mstatus = 32'h0000_1800;
  logic [31:0] m_mtvec   = 32'h8000_0100;
  logic [31:0] m_mepc    = 32'h0;
  logic [31:0] m_mcause  = 32'h0;

  // Reference architectural state, advanced only from the request stream
  logic [31:0] r_mstatus = 32'h0000_1800;
  logic [31:0] r_mtvec   = 32'h8000_0100;
  logic [31:0] r_mepc    = 32'h0;

  always_comb begin
    case (csr_addr)
      12'h300: csr_rdata = m_mstatus;
      12'h305: csr_rdata = m_mtvec;
      12'h341: csr_rdata = m_mepc;
      12'h342: csr_rdata = m_mcause;
      default: csr_rdata = 32'h0;
    endcase
  end
  assign mtvec_in = m_mtvec;
  assign mepc_in  = m_mepc;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (csr_we) begin
      mon_w.cyc  = cyc;
      mon_w.addr = csr_addr;
      mon_w.data = csr_wdata;
      wlog.push_back(mon_w);
      case (csr_addr)
        12'h300: m_mstatus <= csr_wdata;
        12'h305: m_mtvec   <= csr_wdata;
        12'h341: m_mepc    <= csr_wdata;
        12'h342: m_mcause  <= csr_wdata;
        default: ;
      endcase
    end
    if (redirect_valid) begin
      mon_r.cyc = cyc;
      mon_r.pc  = redirect_pc;
      rlog.push_back(mon_r);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic wr_t mk_w(input int c, input logic [11:0] a, input logic [31:0] d);
    wr_t w;
    w.cyc = c; w.addr = a; w.data = d;
    return w;
  endfunction

  // Architectural mstatus updates: trap stacks MIE into MPIE, mret restores it.
  function automatic logic [31:0] trap_ms(input logic [31:0] old);
    return (old & ~32'h0000_1888) | 32'h0000_1800 | ((old & 32'h8) << 4);
  endfunction

  function automatic logic [31:0] mret_ms(input logic [31:0] old);
    return (old & ~32'h0000_1888) | 32'h0000_1880 | ((old & 32'h80) >> 4);
  endfunction

  function automatic logic [31:0] trap_tgt(input logic [31:0] tvec, input logic [31:0] cause);
    logic [31:0] base;
    base = tvec & ~32'h3;
    if (tvec[1:0] == 2'b01 && cause[31]) return base + 32'd4 * (cause & 32'h7fff_ffff);
    return base;
  endfunction

  // Issue one request (0=trap, 1=mret, 2=csrw); called at a negedge with the DUT idle.
  task automatic run(input int kind, input logic [31:0] a, input logic [31:0] b, input logic [11:0] ad);
    wr_t exp_w[$];
    rd_t exp_r[$];
    rd_t r;
    int  n, busy, exp_busy;
    logic [31:0] ns;
    wlog.delete();
    rlog.delete();
    n = cyc;
    exp_busy = 1;
    case (kind)
      0: begin
        ns = trap_ms(r_mstatus);
        exp_w.push_back(mk_w(n + 1, 12'h341, a));
        exp_w.push_back(mk_w(n + 2, 12'h342, b));
        exp_w.push_back(mk_w(n + 3, 12'h300, ns));
        r.cyc = n + 4; r.pc = trap_tgt(r_mtvec, b);
        exp_r.push_back(r);
        r_mepc = a; r_mstatus = ns; exp_busy = 4;
        trap_pc = a; trap_cause = b; trap_valid = 1'b1;
      end
      1: begin
        ns = mret_ms(r_mstatus);
        exp_w.push_back(mk_w(n + 1, 12'h300, ns));
        r.cyc = n + 2; r.pc = r_mepc;
        exp_r.push_back(r);
        r_mstatus = ns; exp_busy = 2;
        mret_valid = 1'b1;
      end
      default: begin
        exp_w.push_back(mk_w(n + 1, ad, a));
        case (ad)
          12'h300: r_mstatus = a;
          12'h305: r_mtvec = a;
          12'h341: r_mepc = a;
          default: ;
        endcase
        csrw_addr = ad; csrw_data = a; csrw_valid = 1'b1;
      end
    endcase
    #1;
    chk("ready_idle", {31'd0, ready}, 32'd1);
    chk("trap_ack", {31'd0, trap_ack}, {31'd0, trap_valid});
    chk("mret_ack", {31'd0, mret_ack}, {31'd0, mret_valid & ~trap_valid});
    chk("csrw_ack", {31'd0, csrw_ack}, {31'd0, csrw_valid & ~trap_valid & ~mret_valid});
    @(posedge clk);
    #1;
    case (kind)
      0: trap_valid = 1'b0;
      1: mret_valid = 1'b0;
      default: csrw_valid = 1'b0;
    endcase
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready) break;
      busy++;
      chk("busy_acks", {29'd0, trap_ack, mret_ack, csrw_ack}, 32'd0);
    end
    chk("busy_cycles", busy, exp_busy);
    chk("wr_count", wlog.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < wlog.size(); i++) begin
      chk("wr_cyc", wlog[i].cyc, exp_w[i].cyc);
      chk("wr_addr", {20'd0, wlog[i].addr}, {20'd0, exp_w[i].addr});
      chk("wr_data", wlog[i].data, exp_w[i].data);
    end
    chk("redir_count", rlog.size(), exp_r.size());
    for (int i = 0; i < exp_r.size() && i < rlog.size(); i++) begin
      chk("redir_cyc", rlog[i].cyc, exp_r[i].cyc);
      chk("redir_pc", rlog[i].pc, exp_r[i].pc);
    end
  endtask

  initial begin
    logic [11:0] addrs [5];
    int          kind;
    logic [11:0] ad;
    logic [31:0] d;
    addrs = '{12'h305, 12'h300, 12'h341, 12'h342, 12'h7c0};

    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_we", {31'd0, csr_we}, 32'd0);
    chk("rst_addr", {20'd0, csr_addr}, 32'd0);
    chk("rst_wdata", csr_wdata, 32'd0);
    chk("rst_rvalid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    trap_valid = 1'b1;
    #1;
    chk("rst_trap_ack", {31'd0, trap_ack}, 32'd1);
    trap_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    run(0, 32'h8000_0010, 32'd11, 12'h0);
    run(2, 32'h0000_0008, 32'd0, 12'h300);
    run(0, 32'h8000_0014, 32'd11, 12'h0);
    run(1, 32'd0, 32'd0, 12'h0);

    // All three requesters at once; losers hold valid until served.
    mret_valid = 1'b1;
    csrw_addr = 12'h305; csrw_data = 32'h8000_0200; csrw_valid = 1'b1;
    run(0, 32'h8000_0020, 32'd11, 12'h0);
    run(1, 32'd0, 32'd0, 12'h0);
    run(2, 32'h8000_0200, 32'd0, 12'h305);
    run(0, 32'h8000_0030, 32'd11, 12'h0);

    run(2, 32'h1234_5678, 32'd0, 12'h342);
    run(2, 32'h8000_0101, 32'd0, 12'h305);
    run(0, 32'h8000_0040, 32'h8000_0003, 12'h0);
    run(0, 32'h8000_0044, 32'd11, 12'h0);

    // Reset while the mcause write is pending.
    wlog.delete();
    rlog.delete();
    trap_pc = 32'h8000_0050; trap_cause = 32'd7; trap_valid = 1'b1;
    @(posedge clk);
    #1 trap_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_addr", {20'd0, csr_addr}, 32'h342);
    rst = 1'b0;
    #1;
    chk("mid_we", {31'd0, csr_we}, 32'd0);
    chk("mid_ready", {31'd0, ready}, 32'd1);
    chk("mid_rpc", redirect_pc, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    r_mepc = 32'h8000_0050;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_rvalid", {31'd0, redirect_valid}, 32'd0);
      chk("mid_ready_post", {31'd0, ready}, 32'd1);
    end
    chk("mid_wr_count", wlog.size(), 32'd1);
    if (wlog.size() > 0) chk("mid_wr_addr", {20'd0, wlog[0].addr}, 32'h341);
    chk("mid_redir_count", rlog.size(), 32'd0);

    for (int k = 0; k < 60; k++) begin
      kind = int'($urandom_range(0, 2));
      if (kind == 2) begin
        ad = addrs[$urandom_range(0, 4)];
        d  = (ad == 12'h305) ? ($urandom & ~32'h2) : $urandom;
        run(2, d, 32'd0, ad);
      end else if (kind == 0) begin
        run(0, $urandom & ~32'h3, (32'($urandom_range(0, 1)) << 31) | 32'($urandom_range(0, 15)), 12'h0);
      end else begin
        run(1, 32'd0, 32'd0, 12'h0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_25040109_trap_ctrl.md
# ysyx_25040109_trap_ctrl

Trap and CSR-write sequencer for the NPC core. The CSR bank has a single write port, so this block sequences every CSR write through it. It arbitrates three requesters: trap entry (ecall), mret, and instruction CSR writes (csrrw/csrrs/csrrc results). It performs the multi-write trap-entry and mret sequences, then issues a one-cycle PC redirect to the IFU.

## Interface
- DATA_WIDTH, 32: width of CSR data, PC and cause.
- VEC_EN, 0: 1 enables vectored mtvec mode. When mtvec[1:0]==01 and cause[31]==1, the target is base + 4*cause[30:0]. 0 ignores the mode bits.

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- trap_valid  in  1  ecall/exception request
- trap_pc  in  32  PC of the trapping instruction
- trap_cause  in  32  mcause value
- mret_valid  in  1  mret request
- csrw_valid  in  1  instruction CSR write request
- csrw_addr  in  12  CSR address
- csrw_data  in  32  CSR write data
- ready  out  1  1 only in IDLE; a request is accepted when its valid and ready are both 1
- trap_ack, mret_ack, csrw_ack  out  1 each  one-cycle pulse in the acceptance cycle (combinational: valid & ready & priority win)
- csr_we  out  1  CSR write enable to the register file
- csr_addr  out  12  CSR address, used for both read and write
- csr_wdata  out  32  CSR write data
- csr_rdata  in  32  combinational CSR read data for csr_addr
- mtvec_in, mepc_in  in  32 each  live mtvec and mepc values
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  32  redirect target, valid while redirect_valid is 1

## Operation
- FSM states: IDLE, T_MEPC, T_MCAUSE, T_MSTAT, M_MSTAT, CSRW, REDIR.
- Acceptance priority in IDLE: trap > mret > csrw. Losing requesters get no ack and must hold valid.
- While not IDLE, ready=0 and all valids are ignored.
- On accept, payload registers capture their inputs: pc_q<=trap_pc, cause_q<=trap_cause, addr_q<=csrw_addr, data_q<=csrw_data.
- State transitions:
  - trap: IDLE->T_MEPC->T_MCAUSE->T_MSTAT->REDIR->IDLE.
  - mret: IDLE->M_MSTAT->REDIR->IDLE.
  - csrw: IDLE->CSRW->IDLE. No redirect is issued.
- csr_* outputs are Moore outputs decoded from state and the payload registers:
  - T_MEPC: we=1, addr=0x341, wdata=pc_q.
  - T_MCAUSE: we=1, addr=0x342, wdata=cause_q.
  - T_MSTAT: we=1, addr=0x300. wdata = csr_rdata with MPIE(bit7)=csr_rdata[3], MIE(bit3)=0, MPP[12:11]=2'b11, all other bits preserved.
  - M_MSTAT: we=1, addr=0x300. wdata = csr_rdata with MIE=csr_rdata[7], MPIE=1, MPP=2'b11.
  - CSRW: we=1, addr=addr_q, wdata=data_q. Unknown addresses are still driven; the register file discards them.
  - Other states: we=0, addr=0, wdata=0.
- Read-modify-write of mstatus completes in one cycle: the read is combinational and the write lands at the state's closing edge.
- Redirect target is latched into redirect_pc on entry to REDIR, using the mode register (trap vs mret) set at acceptance:
  - after trap: mtvec_in & ~3, or the vectored target when VEC_EN applies;
  - after mret: mepc_in.
- redirect_valid is registered and equals 1 exactly while the state is REDIR.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, so ready=1 and the ack pulses follow their valid inputs combinationally;
  - payload registers, redirect_pc and mode clear to 0;
  - csr_we=0, csr_addr=0, csr_wdata=0, redirect_valid=0.
- Reset mid-sequence aborts immediately. No further CSR writes issue; writes already completed remain.
- Trap accepted at edge E:
  - CSR writes occur at edges E+1 (mepc), E+2 (mcause) and E+3 (mstatus);
  - redirect_valid is high during cycle E+3..E+4;
  - ready returns at E+4.
- mret accepted at edge E: mstatus written at E+1; redirect_valid high in cycle E+1..E+2.
- csrw accepted at edge E: write at E+1; ready returns at E+1. Back-to-back csrw accepts every 2 cycles.
- mtvec_in/mepc_in are sampled at REDIR entry, after all sequence writes. A csrw to mtvec completed earlier is visible to a later trap.
- Simultaneous trap_valid and mret_valid: only trap_ack pulses.

## Test plan
- Reset with mstatus=0x1800; trap_pc=0x80000010, cause=11, mtvec=0x80000100 -> writes 0x341=0x80000010, 0x342=0x0000000B, 0x300=0x00001800 in consecutive cycles; redirect_pc=0x80000100 for exactly one cycle.
- mstatus=0x00000008 then trap -> mstatus write 0x00001880. mret with mepc=0x80000014 -> mstatus write 0x00001888; redirect_pc=0x80000014.
- trap_valid, mret_valid and csrw_valid all high in one cycle -> only trap_ack pulses. mret is accepted after the trap redirect, then csrw after the mret redirect; all write orders match the spec.
- csrw addr 0x305, data 0x80000200, then trap -> mtvec written first; trap redirect_pc=0x80000200.
- Assert rst low during T_MCAUSE -> csr_we=0 at once and no mstatus write; after release ready=1 and redirect_valid stays 0.
- VEC_EN=1, mtvec=0x80000101, cause=0x80000003 -> redirect_pc=0x8000010C. With cause=11 -> redirect_pc=0x80000100.
